// File: rtl/mul_ctrl_unit.sv
// Control FSM for the shift-and-add multiplier datapath.
// It loads the two operands over a valid/ready handshake, runs the add loop until B reaches zero, and reports done or err.
module mul_ctrl_unit #(
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             eqz,
  output logic             LdA,
  output logic             LdB,
  output logic             LdP,
  output logic             clrP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_MUL,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] iter_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_next;
      iter_cnt <= iter_next;
    end
  end

  always_comb begin
    state_next = state;
    iter_next  = iter_cnt;
    op_ready   = 1'b0;
    LdA        = 1'b0;
    LdB        = 1'b0;
    LdP        = 1'b0;
    clrP       = 1'b0;
    decB       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state != S_IDLE);

    // Abort wins over every transition and masks all strobes for this cycle.
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_next = S_LDA;
            iter_next  = '0;
          end
        end
        S_LDA: begin
          op_ready = 1'b1;
          LdA      = op_valid;
          if (op_valid) state_next = S_LDB;
        end
        S_LDB: begin
          op_ready = 1'b1;
          LdB      = op_valid;
          clrP     = op_valid;
          if (op_valid) state_next = S_MUL;
        end
        S_MUL: begin
          if (eqz) begin
            state_next = S_DONE;
          end else if (iter_cnt == MAX_ITER) begin
            state_next = S_ERR;
          end else begin
            LdP       = 1'b1;
            decB      = 1'b1;
            iter_next = iter_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
        S_ERR: begin
          err        = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule
